// File: rtl/jk_pkg.sv
// Shared mode and JK action encodings for the JK register bank.
// The bit cell and the top level both decode against these definitions.
package jk_pkg;

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Encoding is {j,k}, so a cell's inputs cast directly to an action.
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_action_e;

    function automatic logic jk_apply(input jk_action_e act, input logic q);
        logic nxt;
        nxt = q;
        case (act)
            JK_HOLD: nxt = q;
            JK_CLR:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            JK_TGL:  nxt = ~q;
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_bit_cell.sv
// Combinational next-state of a single JK flip-flop.
// Holds no state; the bank owns the storage.
module jk_bit_cell
    import jk_pkg::*;
(
    input  logic j,
    input  logic k,
    input  logic q,
    output logic q_next
);

    jk_action_e act;

    always_comb begin
        act    = jk_action_e'({j, k});
        q_next = jk_apply(act, q);
    end

endmodule

// File: rtl/jk_register_bank.sv
// Bank of WIDTH JK flip-flops: per-bit JK, up/down counter or parallel load.
// q, qn, tc and changed are all registered on the same edge.
module jk_register_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             changed
);

    logic [WIDTH-1:0] ones_below;
    logic [WIDTH-1:0] zeros_below;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic [WIDTH-1:0] q_next;
    logic             tc_next;

    // Ripple-free toggle enables: bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        ones_below     = '0;
        zeros_below    = '0;
        ones_below[0]  = 1'b1;
        zeros_below[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            ones_below[i]  = ones_below[i-1]  &  q[i-1];
            zeros_below[i] = zeros_below[i-1] & ~q[i-1];
        end
    end

    always_comb begin
        cell_j  = j;
        cell_k  = k;
        tc_next = 1'b0;
        case (mode)
            MODE_JK: begin
                cell_j = j;
                cell_k = k;
            end
            MODE_UP: begin
                cell_j  = ones_below;
                cell_k  = ones_below;
                tc_next = &q;
            end
            MODE_DOWN: begin
                cell_j  = zeros_below;
                cell_k  = zeros_below;
                tc_next = ~|q;
            end
            MODE_LOAD: begin
                cell_j = d;
                cell_k = ~d;
            end
            default: begin
                cell_j = j;
                cell_k = k;
            end
        endcase
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_bit_cell u_cell (
            .j      (cell_j[gi]),
            .k      (cell_k[gi]),
            .q      (q[gi]),
            .q_next (q_next[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= RESET_VAL;
            qn      <= ~RESET_VAL;
            tc      <= 1'b0;
            changed <= 1'b0;
        end else if (en) begin
            q       <= q_next;
            qn      <= ~q_next;
            tc      <= tc_next;
            changed <= (q_next != q);
        end else begin
            tc      <= 1'b0;
            changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jk_register_bank.sv
// Directed plus randomized check of jk_register_bank at WIDTH=4 and WIDTH=1
// against an arithmetic reference model.
module tb_jk_register_bank;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j, k, d;
    logic [3:0] q4, qn4;
    logic       tc4, chg4;
    logic [0:0] q1, qn1;
    logic       tc1, chg1;

    int n_tests;
    int n_fail;

    logic [31:0] m_q4, m_q1;

    jk_register_bank #(.WIDTH(4), .RESET_VAL(4'h5)) u_dut4 (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .j(j), .k(k), .d(d),
        .q(q4), .qn(qn4), .tc(tc4), .changed(chg4)
    );

    jk_register_bank #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .j(j[0:0]), .k(k[0:0]), .d(d[0:0]),
        .q(q1), .qn(qn1), .tc(tc1), .changed(chg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model(input int w, input logic [31:0] rv, input logic [31:0] cur,
                         output logic [31:0] nxt, output logic [31:0] nqn,
                         output logic [31:0] ntc, output logic [31:0] nchg);
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        ntc  = 0;
        nchg = 0;
        if (reset) begin
            nxt = rv;
        end else if (!en) begin
            nxt = cur;
        end else begin
            case (mode)
                2'b00: begin
                    nxt = cur;
                    for (int i = 0; i < w; i++) begin
                        if (j[i] && k[i])  nxt[i] = ~cur[i];
                        else if (j[i])     nxt[i] = 1'b1;
                        else if (k[i])     nxt[i] = 1'b0;
                    end
                end
                2'b01: begin
                    nxt = (cur + 1) & mask;
                    ntc = (cur == mask) ? 1 : 0;
                end
                2'b10: begin
                    nxt = (cur - 1) & mask;
                    ntc = (cur == 0) ? 1 : 0;
                end
                default: nxt = {28'd0, d} & mask;
            endcase
            nchg = (nxt != cur) ? 1 : 0;
        end
        nqn = ~nxt & mask;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] dd);
        logic [31:0] eq4, eqn4, etc4, ech4, eq1, eqn1, etc1, ech1;
        reset = r; en = e; mode = m; j = jj; k = kk; d = dd;
        model(4, 32'h5, m_q4, eq4, eqn4, etc4, ech4);
        model(1, 32'h0, m_q1, eq1, eqn1, etc1, ech1);
        @(posedge clk);
        #1;
        m_q4 = eq4;
        m_q1 = eq1;
        check("q4",   {28'd0, q4},   eq4);
        check("qn4",  {28'd0, qn4},  eqn4);
        check("tc4",  {31'd0, tc4},  etc4);
        check("chg4", {31'd0, chg4}, ech4);
        check("q1",   {31'd0, q1},   eq1);
        check("qn1",  {31'd0, qn1},  eqn1);
        check("tc1",  {31'd0, tc1},  etc1);
        check("chg1", {31'd0, chg1}, ech1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_q4 = 0;
        m_q1 = 0;
        reset = 1'b0; en = 1'b0; mode = 2'b00; j = '0; k = '0; d = '0;
        @(negedge clk);

        // Reset wins over en=0 and counter mode.
        step(1, 0, 2'b01, 4'h0, 4'h0, 4'h0);
        check("rst_q", {28'd0, q4}, 32'h5);
        check("rst_qn", {28'd0, qn4}, 32'hA);

        // JK: toggle, set, clear, hold on bits 3..0.
        step(0, 1, 2'b00, 4'b1100, 4'b1010, 4'h0);
        check("jk_q", {28'd0, q4}, 32'hD);
        check("jk_qn", {28'd0, qn4}, 32'h2);

        // Up count across the wrap.
        step(0, 1, 2'b11, 4'h0, 4'h0, 4'hE);
        step(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);
        step(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);
        check("up_wrap_tc", {31'd0, tc4}, 32'h1);
        step(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);

        // Down count across the wrap, then hold.
        step(0, 1, 2'b11, 4'h0, 4'h0, 4'h1);
        step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0);
        step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0);
        check("dn_wrap_q", {28'd0, q4}, 32'hF);
        step(0, 0, 2'b10, 4'h0, 4'h0, 4'h0);
        step(0, 0, 2'b10, 4'h0, 4'h0, 4'h0);

        // Repeated load of the same value shows no change.
        step(0, 1, 2'b11, 4'h0, 4'h0, 4'h9);
        step(0, 1, 2'b11, 4'h0, 4'h0, 4'h9);
        check("reload_chg", {31'd0, chg4}, 32'h0);

        // Reset mid-count, then resume from RESET_VAL.
        step(0, 1, 2'b11, 4'h0, 4'h0, 4'h7);
        step(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);
        step(1, 1, 2'b01, 4'h0, 4'h0, 4'h0);
        step(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);
        check("resume_q", {28'd0, q4}, 32'h6);

        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) != 0),
                 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
